// File: rtl/ov7670_dvp_tx.sv
// ov7670_dvp_tx
//   Sensor emulator for the OV7670 DVP interface. It drives VSYNC, HREF and
//   an 8-bit data bus with RGB565 timing and byte order, synchronous to pclk.
//   Pixels come from an upstream valid/ready stream. With
//   OV7670_DVP_TX_PATTERN_EN defined, an internal 8-bar colour-bar generator
//   can take the place of the stream.
//
// Ports
//   pclk, reset      rising-edge clock; asynchronous active-high reset
//   enable           start a frame; only looked at on frame boundaries
//   pix_data/valid   RGB565 pixel stream input
//   pix_ready        combinational: a pixel is taken this cycle
//   vsync, href, d   DVP outputs (registered)
//   frame_done       one-cycle pulse on the last V_BACK cycle (registered)
//   busy             state is not IDLE
//   underflow        sticky: a pixel slot found pix_valid low (registered)
//   underflow_clr    clears underflow; a set in the same cycle wins
//   pattern_sel      only with OV7670_DVP_TX_PATTERN_EN; 1 = colour bars
module ov7670_dvp_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 3136,
  parameter int V_FRONT   = 2,
  parameter int V_BACK    = 2
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic        busy,
  output logic        underflow,
  input  logic        underflow_clr
`ifdef OV7670_DVP_TX_PATTERN_EN
  ,
  input  logic        pattern_sel
`endif
);

  localparam int LINE_LEN = 2 * H_ACTIVE;
  localparam int HMAX_A   = (VSYNC_LEN > LINE_LEN) ? VSYNC_LEN : LINE_LEN;
  localparam int HMAX     = (HMAX_A > H_BLANK) ? HMAX_A : H_BLANK;
  localparam int HW       = $clog2(HMAX + 1);
  localparam int LW       = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_V_FRONT, S_LINE, S_H_BLANK, S_V_BACK
  } state_t;

  state_t        state_r, state_next_s;
  logic [HW-1:0] hcnt_r, hcnt_next_s;
  logic [LW-1:0] lcnt_r, lcnt_next_s;
  logic          load_s;
  logic          uf_set_s;
  logic [15:0]   pixel_s;
  logic [7:0]    lo_byte_r;
  logic          pat_r;

  // Next-state and counter logic; hcnt restarts from zero on every transition
  always_comb begin
    state_next_s = state_r;
    hcnt_next_s  = hcnt_r;
    lcnt_next_s  = lcnt_r;
    case (state_r)
      S_IDLE: begin
        if (enable) begin
          state_next_s = S_VSYNC;
          hcnt_next_s  = '0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_VSYNC: begin
        if (hcnt_r == HW'(VSYNC_LEN - 1)) begin
          state_next_s = S_V_FRONT;
          hcnt_next_s  = '0;
        end else begin
          hcnt_next_s  = hcnt_r + HW'(1);
        end
      end
      S_V_FRONT: begin
        if (hcnt_r == HW'(V_FRONT - 1)) begin
          state_next_s = S_LINE;
          hcnt_next_s  = '0;
        end else begin
          hcnt_next_s  = hcnt_r + HW'(1);
        end
      end
      S_LINE: begin
        if (hcnt_r == HW'(LINE_LEN - 1)) begin
          hcnt_next_s = '0;
          if (lcnt_r == LW'(V_ACTIVE - 1)) begin
            state_next_s = S_V_BACK;
            lcnt_next_s  = '0;
          end else begin
            state_next_s = S_H_BLANK;
            lcnt_next_s  = lcnt_r + LW'(1);
          end
        end else begin
          hcnt_next_s = hcnt_r + HW'(1);
        end
      end
      S_H_BLANK: begin
        if (hcnt_r == HW'(H_BLANK - 1)) begin
          state_next_s = S_LINE;
          hcnt_next_s  = '0;
        end else begin
          hcnt_next_s  = hcnt_r + HW'(1);
        end
      end
      S_V_BACK: begin
        if (hcnt_r == HW'(V_BACK - 1)) begin
          state_next_s = enable ? S_VSYNC : S_IDLE;
          hcnt_next_s  = '0;
        end else begin
          hcnt_next_s  = hcnt_r + HW'(1);
        end
      end
      default: begin
        state_next_s = S_IDLE;
        hcnt_next_s  = '0;
        lcnt_next_s  = '0;
      end
    endcase
  end

  // A pixel is fetched in the cycle before every even (high-byte) slot of a line
  assign load_s = (state_next_s == S_LINE) && (hcnt_next_s[0] == 1'b0);
  assign busy   = (state_r != S_IDLE);

`ifdef OV7670_DVP_TX_PATTERN_EN
  // Colour of the bar covering a given pixel column
  function automatic logic [15:0] bar_color(input int col);
    case ((col * 8) / H_ACTIVE)
      0:       bar_color = 16'hFFFF;
      1:       bar_color = 16'hFFE0;
      2:       bar_color = 16'h07FF;
      3:       bar_color = 16'h07E0;
      4:       bar_color = 16'hF81F;
      5:       bar_color = 16'hF800;
      6:       bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Pixel source select: the column of the upcoming pixel is hcnt_next/2
  always_comb begin
    pix_ready = load_s && !pat_r;
    uf_set_s  = pix_ready && !pix_valid;
    if (pat_r) begin
      pixel_s = bar_color(int'(hcnt_next_s >> 1));
    end else begin
      pixel_s = pix_valid ? pix_data : 16'h0000;
    end
  end

  // Pattern select is captured on entry to VSYNC and held for the whole frame
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      pat_r <= 1'b0;
    end else if ((state_next_s == S_VSYNC) && (state_r != S_VSYNC)) begin
      pat_r <= pattern_sel;
    end else begin
      pat_r <= pat_r;
    end
  end
`else
  assign pat_r = 1'b0;

  // Stream-only pixel source; a missing pixel is replaced by black
  always_comb begin
    pix_ready = load_s && !pat_r;
    uf_set_s  = pix_ready && !pix_valid;
    pixel_s   = pix_valid ? pix_data : 16'h0000;
  end
`endif

  // State, counters and outputs; outputs are computed from next-state values
  // so they line up with the state they describe
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      hcnt_r     <= '0;
      lcnt_r     <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      lo_byte_r  <= 8'h00;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      hcnt_r     <= hcnt_next_s;
      lcnt_r     <= lcnt_next_s;
      vsync      <= (state_next_s == S_VSYNC);
      href       <= (state_next_s == S_LINE);
      frame_done <= (state_next_s == S_V_BACK) && (hcnt_next_s == HW'(V_BACK - 1));
      if (load_s) begin
        d         <= pixel_s[15:8];
        lo_byte_r <= pixel_s[7:0];
      end else if (state_next_s == S_LINE) begin
        d         <= lo_byte_r;
      end else begin
        d         <= 8'h00;
      end
      if (uf_set_s) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end else begin
        underflow <= underflow;
      end
    end
  end

endmodule
